// File: rtl/alu_pkg.sv
// Shared command encodings, FSM state type and decode helper for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0001;
    localparam logic [3:0] CMD_XOR  = 4'b0010;
    localparam logic [3:0] CMD_SLT  = 4'b0011;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_NAND = 4'b0101;
    localparam logic [3:0] CMD_NOR  = 4'b0110;
    localparam logic [3:0] CMD_OR   = 4'b0111;
    localparam logic [3:0] CMD_MUL  = 4'b1000;
    localparam logic [3:0] CMD_SLL  = 4'b1001;
    localparam logic [3:0] CMD_SRL  = 4'b1010;
    localparam logic [3:0] CMD_SRA  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    function automatic logic cmd_reserved(input logic [3:0] cmd);
        return cmd[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/command and result/flag handshake bundle between the CPU pipeline and alu_seq.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [3:0]       command;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;
    logic             error;
    logic             busy;

    modport master (
        output in_valid, operand_a, operand_b, command, out_ready,
        input  in_ready, out_valid, result, carryout, overflow, zero, error, busy
    );

    modport slave (
        input  in_valid, operand_a, operand_b, command, out_ready,
        output in_ready, out_valid, result, carryout, overflow, zero, error, busy
    );
endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: add/sub/slt with ripple carry and signed overflow, plus logic ops.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             cin_msb;
    logic             ovf;

    always_comb begin
        sub      = ({1'b0, op} == CMD_SUB) || ({1'b0, op} == CMD_SLT);
        b_eff    = sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        // Carry into the MSB recovered from the MSB sum bit and its two inputs.
        cin_msb  = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
        ovf      = cin_msb ^ sum[WIDTH];
        result   = '0;
        carryout = 1'b0;
        overflow = 1'b0;
        case ({1'b0, op})
            CMD_ADD, CMD_SUB: begin
                result   = sum[WIDTH-1:0];
                carryout = sum[WIDTH];
                overflow = ovf;
            end
            CMD_SLT: begin
                result   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
                carryout = sum[WIDTH];
                overflow = ovf;
            end
            CMD_XOR:  result = a ^ b;
            CMD_AND:  result = a & b;
            CMD_NAND: result = ~(a & b);
            CMD_NOR:  result = ~(a | b);
            CMD_OR:   result = a | b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops via alu_core, shift-add MUL and one-bit-per-cycle shifts,
// with valid/ready on both sides and registered result/flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = SH_W + 1;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op;
    logic [2*WIDTH-1:0] acc, mcand, acc_nx;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   shreg, sh_nx;
    logic               sh_out;

    logic [WIDTH-1:0]   res_q;
    logic               cy_q, ov_q, z_q, err_q;

    logic [WIDTH-1:0]   core_res;
    logic               core_cy, core_ov;

    logic               accept, finish, starts_exec, in_ready_c;
    logic [SH_W-1:0]    k_in;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (bus.operand_a),
        .b        (bus.operand_b),
        .op       (bus.command[2:0]),
        .result   (core_res),
        .carryout (core_cy),
        .overflow (core_ov)
    );

    assign k_in        = bus.operand_b[SH_W-1:0];
    assign starts_exec = (bus.command == CMD_MUL) ||
                         ((bus.command[3:2] == 2'b10) && (k_in != '0));

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        finish     = 1'b0;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                accept     = bus.in_valid;
            end
            EXEC: begin
                if (cnt == CNT_W'(1)) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) accept = 1'b1;
                    else state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (accept) state_nx = starts_exec ? EXEC : DONE;
        if (!rst_n) in_ready_c = 1'b0;
    end

    always_comb begin
        acc_nx = acc + (mplier[0] ? mcand : '0);
        sh_nx  = shreg;
        sh_out = 1'b0;
        case (op[1:0])
            2'b01: begin sh_nx = {shreg[WIDTH-2:0], 1'b0};          sh_out = shreg[WIDTH-1]; end
            2'b10: begin sh_nx = {1'b0, shreg[WIDTH-1:1]};          sh_out = shreg[0];       end
            2'b11: begin sh_nx = {shreg[WIDTH-1], shreg[WIDTH-1:1]}; sh_out = shreg[0];       end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            shreg  <= '0;
            res_q  <= '0;
            cy_q   <= 1'b0;
            ov_q   <= 1'b0;
            z_q    <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op <= bus.command;
                if (!bus.command[3]) begin
                    res_q <= core_res;
                    cy_q  <= core_cy;
                    ov_q  <= core_ov;
                    z_q   <= (core_res == '0);
                    err_q <= 1'b0;
                end else if (cmd_reserved(bus.command)) begin
                    res_q <= '0;
                    cy_q  <= 1'b0;
                    ov_q  <= 1'b0;
                    z_q   <= 1'b1;
                    err_q <= 1'b1;
                end else if (bus.command == CMD_MUL) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, bus.operand_a};
                    mplier <= bus.operand_b;
                    cnt    <= CNT_W'(WIDTH);
                end else begin
                    shreg <= bus.operand_a;
                    cnt   <= {1'b0, k_in};
                    if (k_in == '0) begin
                        res_q <= bus.operand_a;
                        cy_q  <= 1'b0;
                        ov_q  <= 1'b0;
                        z_q   <= (bus.operand_a == '0);
                        err_q <= 1'b0;
                    end
                end
            end else if (state == EXEC) begin
                cnt <= cnt - CNT_W'(1);
                if (op == CMD_MUL) begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end else begin
                    shreg <= sh_nx;
                end
                if (finish) begin
                    ov_q  <= 1'b0;
                    err_q <= 1'b0;
                    if (op == CMD_MUL) begin
                        res_q <= acc_nx[WIDTH-1:0];
                        cy_q  <= |acc_nx[2*WIDTH-1:WIDTH];
                        z_q   <= (acc_nx[WIDTH-1:0] == '0);
                    end else begin
                        res_q <= sh_nx;
                        cy_q  <= sh_out;
                        z_q   <= (sh_nx == '0);
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == EXEC);
    assign bus.result    = res_q;
    assign bus.carryout  = cy_q;
    assign bus.overflow  = ov_q;
    assign bus.zero      = z_q;
    assign bus.error     = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expected results, a negedge monitor pops on handshake.
module tb_alu_seq;

    logic clk;
    logic rst_n;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        cy;
        logic        ov;
        logic        z;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: {result, carryout, overflow, zero, error} compared on each accepted output.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result=%h expected no output", bus.result);
            end else begin
                e = sb.pop_front();
                chk(e.name,
                    64'({bus.result, bus.carryout, bus.overflow, bus.zero, bus.error}),
                    64'({e.res, e.cy, e.ov, e.z, e.err}));
            end
        end
    end

    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic cy, input logic ov, input logic z,
                         input logic err, input string name, input bit push);
        int guard;
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.command   = cmd;
        bus.operand_a = a;
        bus.operand_b = b;
        if (push) begin
            e.name = name; e.res = res; e.cy = cy; e.ov = ov; e.z = z; e.err = err;
            sb.push_back(e);
        end
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk({name, "_accept_timeout"}, 64'(0), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.command   = 4'b0000;
        bus.operand_a = '1;
        bus.operand_b = '1;
    endtask

    task automatic wait_valid(input int exp_lat, input string name, output int busy_cnt);
        int lat;
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid && bus.busy && !bus.in_ready) busy_cnt++;
        end while (!bus.out_valid && lat < 200);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    int bc;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.command   = 4'b0000;
        bus.operand_a = '0;
        bus.operand_b = '0;

        @(negedge clk);
        chk("reset_in_ready_low", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_outputs", 64'({bus.out_valid, bus.busy, bus.result, bus.carryout,
                                  bus.overflow, bus.zero, bus.error}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;

        // Single-cycle ops
        issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, "add_ovf", 1'b1);
        wait_valid(1, "add_ovf", bc);
        issue(4'b0001, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "sub_zero", 1'b1);
        wait_valid(1, "sub_zero", bc);
        issue(4'b0011, 32'h8000_0000, 32'h0000_0001, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0, "slt_ovf", 1'b1);
        wait_valid(1, "slt_ovf", bc);
        issue(4'b0010, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0, 1'b0, "xor", 1'b1);
        wait_valid(1, "xor", bc);
        issue(4'b0110, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "nor_zero", 1'b1);
        wait_valid(1, "nor_zero", bc);

        // Multiply
        issue(4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "mul_big", 1'b1);
        wait_valid(33, "mul_big", bc);
        chk("mul_busy_cycles", 64'(bc), 64'(32));
        issue(4'b1000, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 1'b0, 1'b0, "mul_7x6", 1'b1);
        wait_valid(33, "mul_7x6", bc);

        // Shifts
        issue(4'b1011, 32'hF000_0000, 32'd4, 32'hFF00_0000, 1'b0, 1'b0, 1'b0, 1'b0, "sra4", 1'b1);
        wait_valid(5, "sra4", bc);
        issue(4'b1001, 32'h8000_0001, 32'd1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0, "sll1", 1'b1);
        wait_valid(2, "sll1", bc);
        issue(4'b1010, 32'h1234_5678, 32'h0000_0100, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, "srl0", 1'b1);
        wait_valid(1, "srl0", bc);
        issue(4'b1010, 32'h0000_0013, 32'd2, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b0, "srl2", 1'b1);
        wait_valid(3, "srl2", bc);

        // Backpressure, then back-to-back accept from DONE
        bus.out_ready = 1'b0;
        issue(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0, "and_held", 1'b1);
        wait_valid(1, "and_held", bc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_state", 64'({bus.out_valid, bus.in_ready, bus.result, bus.carryout,
                                   bus.overflow, bus.zero, bus.error}),
                64'({1'b1, 1'b0, 32'hF000_F000, 4'b0000}));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.command   = 4'b0111;
        bus.operand_a = 32'h0F0F_0000;
        bus.operand_b = 32'h0000_00FF;
        sb.push_back('{name: "or_b2b", res: 32'h0F0F_00FF, cy: 1'b0, ov: 1'b0, z: 1'b0, err: 1'b0});
        @(negedge clk);
        chk("done_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        wait_valid(1, "or_b2b", bc);

        // Reset mid-multiply aborts the op
        issue(4'b1000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0, "mul_abort", 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_low", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_abort", 64'({bus.out_valid, bus.busy, bus.in_ready, bus.result, bus.carryout,
                                bus.overflow, bus.zero, bus.error}),
            64'({1'b0, 1'b0, 1'b1, 32'h0, 4'b0000}));
        repeat (40) @(posedge clk);
        #1;

        // Reserved command
        issue(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, "reserved", 1'b1);
        wait_valid(1, "reserved", bc);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
